// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: shares one Avalon-MM framebuffer memory port between the
// display scanout host (host 0, fixed priority) and the draw engine (host 1,
// protected by a starvation counter). The memory command is registered, and
// an owner FIFO routes each pipelined read return back to the host that
// issued the read.
module fb_mem_arbiter #(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 16,
    parameter int MAX_PENDING  = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,

    input  logic [ADDR_W-1:0]              h0_address,
    input  logic                           h0_read,
    input  logic                           h0_write,
    input  logic [DATA_W-1:0]              h0_writedata,
    output logic                           h0_waitrequest,
    output logic [DATA_W-1:0]              h0_readdata,
    output logic                           h0_readdatavalid,

    input  logic [ADDR_W-1:0]              h1_address,
    input  logic                           h1_read,
    input  logic                           h1_write,
    input  logic [DATA_W-1:0]              h1_writedata,
    output logic                           h1_waitrequest,
    output logic [DATA_W-1:0]              h1_readdata,
    output logic                           h1_readdatavalid,

    output logic [ADDR_W-1:0]              m_address,
    output logic                           m_read,
    output logic                           m_write,
    output logic [DATA_W-1:0]              m_writedata,
    input  logic                           m_waitrequest,
    input  logic [DATA_W-1:0]              m_readdata,
    input  logic                           m_readdatavalid,

    output logic [$clog2(MAX_PENDING):0]   pending_count,
    output logic                           err_rdv
);

    localparam int                PTR_W      = $clog2(MAX_PENDING);
    localparam int                CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]  PEND_MAX   = CNT_W'(MAX_PENDING);
    localparam logic [7:0]        STARVE_THR = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_H0   = 2'd1,
        GNT_H1   = 2'd2
    } grant_t;

    grant_t              grant;
    logic                slot_free;
    logic                can_read;
    logic                h0_req;
    logic                h1_req;
    logic                h0_elig;
    logic                h1_elig;
    logic [7:0]          starve_cnt;

    logic [ADDR_W-1:0]   sel_address;
    logic [DATA_W-1:0]   sel_writedata;
    logic                sel_write;
    logic                sel_read;

    logic                owner_q [MAX_PENDING];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                fifo_empty;
    logic                owner_head;
    logic                push;
    logic                pop;

    // The memory command slot can take a new command when it is idle or
    // the command currently presented is being accepted this cycle.
    assign slot_free  = !(m_read || m_write) || !m_waitrequest;
    assign can_read   = pending_count < PEND_MAX;
    assign h0_req     = h0_read || h0_write;
    assign h1_req     = h1_read || h1_write;
    assign h0_elig    = h0_req && (h0_write || can_read);
    assign h1_elig    = h1_req && (h1_write || can_read);

    assign fifo_empty = (pending_count == '0);
    assign owner_head = owner_q[rd_ptr];

    // Arbitration: starving host 1 first, then host 0, then host 1.
    // Nothing is granted while reset is held so both hosts see waitrequest.
    always_comb begin
        grant = GNT_NONE;
        if (reset_n && slot_free) begin
            if (h1_elig && (starve_cnt >= STARVE_THR)) begin
                grant = GNT_H1;
            end else if (h0_elig) begin
                grant = GNT_H0;
            end else if (h1_elig) begin
                grant = GNT_H1;
            end
        end
    end

    // Mux the winning host's command; a simultaneous read+write is a write.
    always_comb begin
        sel_address   = h0_address;
        sel_writedata = h0_writedata;
        sel_write     = h0_write;
        sel_read      = h0_read && !h0_write;
        if (grant == GNT_H1) begin
            sel_address   = h1_address;
            sel_writedata = h1_writedata;
            sel_write     = h1_write;
            sel_read      = h1_read && !h1_write;
        end
    end

    assign h0_waitrequest   = (grant != GNT_H0);
    assign h1_waitrequest   = (grant != GNT_H1);

    assign push             = (grant != GNT_NONE) && sel_read;
    assign pop              = reset_n && m_readdatavalid && !fifo_empty;

    assign h0_readdata      = m_readdata;
    assign h1_readdata      = m_readdata;
    assign h0_readdatavalid = pop && !owner_head;
    assign h1_readdatavalid = pop && owner_head;

    // Registered memory command: load on grant, drop to idle when the slot
    // frees with no winner, hold while the memory stalls.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m_address   <= '0;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            m_writedata <= '0;
        end else if (slot_free) begin
            if (grant != GNT_NONE) begin
                m_address   <= sel_address;
                m_writedata <= sel_writedata;
                m_write     <= sel_write;
                m_read      <= sel_read;
            end else begin
                m_read      <= 1'b0;
                m_write     <= 1'b0;
            end
        end
    end

    // Owner storage: one bit per outstanding read naming the issuing host.
    // NOTE: the storage array has no reset; validity comes from the reset
    // pointers and count, so clearing the entries would only add logic.
    always_ff @(posedge clk) begin
        if (push) begin
            owner_q[wr_ptr] <= (grant == GNT_H1);
        end
    end

    // FIFO pointers and outstanding-read count; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            pending_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   pending_count <= pending_count + CNT_W'(1);
                2'b01:   pending_count <= pending_count - CNT_W'(1);
                default: pending_count <= pending_count;
            endcase
        end
    end

    // Starvation counter: counts host 1 waiting cycles, saturating at 255.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!h1_req || (grant == GNT_H1)) begin
            starve_cnt <= '0;
        end else if (starve_cnt != 8'hFF) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // Sticky flag for a read return that no outstanding read accounts for.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_rdv <= 1'b0;
        end else if (m_readdatavalid && fifo_empty) begin
            err_rdv <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb_fb_mem_arbiter: directed checks of fb_mem_arbiter with hand-computed
// expected values. Inputs are driven 1 time unit after the rising edge and
// outputs are sampled 1 time unit later, well away from the next edge.
module tb_fb_mem_arbiter;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    logic               clk = 1'b0;
    logic               reset_n;

    logic [ADDR_W-1:0]  h0_address;
    logic               h0_read;
    logic               h0_write;
    logic [DATA_W-1:0]  h0_writedata;
    logic               h0_waitrequest;
    logic [DATA_W-1:0]  h0_readdata;
    logic               h0_readdatavalid;

    logic [ADDR_W-1:0]  h1_address;
    logic               h1_read;
    logic               h1_write;
    logic [DATA_W-1:0]  h1_writedata;
    logic               h1_waitrequest;
    logic [DATA_W-1:0]  h1_readdata;
    logic               h1_readdatavalid;

    logic [ADDR_W-1:0]  m_address;
    logic               m_read;
    logic               m_write;
    logic [DATA_W-1:0]  m_writedata;
    logic               m_waitrequest;
    logic [DATA_W-1:0]  m_readdata;
    logic               m_readdatavalid;

    logic [3:0]         pending_count;
    logic               err_rdv;

    int                 n_checks = 0;
    int                 n_fail   = 0;

    fb_mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .MAX_PENDING  (8),
        .STARVE_LIMIT (16)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .h0_address       (h0_address),
        .h0_read          (h0_read),
        .h0_write         (h0_write),
        .h0_writedata     (h0_writedata),
        .h0_waitrequest   (h0_waitrequest),
        .h0_readdata      (h0_readdata),
        .h0_readdatavalid (h0_readdatavalid),
        .h1_address       (h1_address),
        .h1_read          (h1_read),
        .h1_write         (h1_write),
        .h1_writedata     (h1_writedata),
        .h1_waitrequest   (h1_waitrequest),
        .h1_readdata      (h1_readdata),
        .h1_readdatavalid (h1_readdatavalid),
        .m_address        (m_address),
        .m_read           (m_read),
        .m_write          (m_write),
        .m_writedata      (m_writedata),
        .m_waitrequest    (m_waitrequest),
        .m_readdata       (m_readdata),
        .m_readdatavalid  (m_readdatavalid),
        .pending_count    (pending_count),
        .err_rdv          (err_rdv)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    // Interleaved read table: issuing host, address, returned data.
    logic        rd_host [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [19:0] rd_addr [4] = '{20'h00010, 20'h00020, 20'h00030, 20'h00040};
    logic [15:0] rd_data [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    initial begin
        reset_n         = 1'b0;
        h0_address      = 20'h00FFF;
        h0_read         = 1'b0;
        h0_write        = 1'b1;
        h0_writedata    = 16'hFFFF;
        h1_address      = '0;
        h1_read         = 1'b0;
        h1_write        = 1'b0;
        h1_writedata    = '0;
        m_waitrequest   = 1'b0;
        m_readdata      = '0;
        m_readdatavalid = 1'b0;

        // Reset state, with host 0 requesting to show reset blocks grants.
        cyc();
        cyc();
        check("rst_m_read",       m_read,         0);
        check("rst_m_write",      m_write,        0);
        check("rst_m_address",    m_address,      0);
        check("rst_m_writedata",  m_writedata,    0);
        check("rst_pending",      pending_count,  0);
        check("rst_err",          err_rdv,        0);
        check("rst_h0_wait",      h0_waitrequest, 1);
        check("rst_h1_wait",      h1_waitrequest, 1);
        check("rst_h0_rdv",       h0_readdatavalid, 0);
        h0_write = 1'b0;
        reset_n  = 1'b1;
        cyc();

        // Single host 0 write with an idle memory.
        h0_write     = 1'b1;
        h0_address   = 20'h00123;
        h0_writedata = 16'hABCD;
        settle();
        check("wr0_c0_h0_wait", h0_waitrequest, 0);
        cyc();
        h0_write = 1'b0;
        settle();
        check("wr0_c1_m_write",  m_write,     1);
        check("wr0_c1_m_addr",   m_address,   20'h00123);
        check("wr0_c1_m_wdata",  m_writedata, 16'hABCD);
        check("wr0_c1_m_read",   m_read,      0);
        cyc();
        check("wr0_c2_m_write",  m_write,     0);

        // Simultaneous writes under a 3-cycle memory stall.
        m_waitrequest = 1'b1;
        h0_write      = 1'b1;
        h0_address    = 20'h0A000;
        h0_writedata  = 16'h00A0;
        h1_write      = 1'b1;
        h1_address    = 20'h0B000;
        h1_writedata  = 16'h00B1;
        settle();
        check("both_c0_h0_wait", h0_waitrequest, 0);
        check("both_c0_h1_wait", h1_waitrequest, 1);
        cyc();
        h0_write = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            settle();
            check("both_stall_m_write", m_write,        1);
            check("both_stall_m_addr",  m_address,      20'h0A000);
            check("both_stall_h1_wait", h1_waitrequest, 1);
            if (i < 3) cyc();
            else begin
                @(posedge clk);
                #1;
            end
        end
        m_waitrequest = 1'b0;
        settle();
        check("both_c4_h1_wait", h1_waitrequest, 0);
        cyc();
        h1_write = 1'b0;
        settle();
        check("both_c5_m_addr",  m_address,   20'h0B000);
        check("both_c5_m_wdata", m_writedata, 16'h00B1);
        check("both_c5_m_write", m_write,     1);
        cyc();
        check("both_c6_m_write", m_write,     0);

        // Starvation: host 0 writes every cycle, host 1 waits 16 cycles.
        h0_write   = 1'b1;
        h0_address = 20'h0AAAA;
        h1_write   = 1'b1;
        h1_address = 20'h05555;
        for (int i = 0; i < 16; i++) begin
            settle();
            check("starve_h0_wins",  h0_waitrequest, 0);
            check("starve_h1_waits", h1_waitrequest, 1);
            cyc();
        end
        settle();
        check("starve_16_h1_wait", h1_waitrequest, 0);
        check("starve_16_h0_wait", h0_waitrequest, 1);
        cyc();
        check("starve_17_m_addr",  m_address,      20'h05555);
        check("starve_17_h0_wait", h0_waitrequest, 0);
        check("starve_17_h1_wait", h1_waitrequest, 1);
        cyc();
        h0_write = 1'b0;
        h1_write = 1'b0;
        cyc();

        // Interleaved reads h0,h1,h0,h1, each returned 5 cycles after issue.
        for (int i = 0; i < 4; i++) begin
            h0_read    = !rd_host[i];
            h1_read    = rd_host[i];
            h0_address = rd_addr[i];
            h1_address = rd_addr[i];
            settle();
            check("rd_grant_wait", rd_host[i] ? h1_waitrequest : h0_waitrequest, 0);
            cyc();
            h0_read = 1'b0;
            h1_read = 1'b0;
            settle();
            check("rd_m_read", m_read,    1);
            check("rd_m_addr", m_address, rd_addr[i]);
        end
        check("rd_pending_peak", pending_count, 4);
        cyc();
        check("rd_pending_hold", pending_count, 4);
        cyc();
        for (int i = 0; i < 4; i++) begin
            m_readdatavalid = 1'b1;
            m_readdata      = rd_data[i];
            settle();
            check("rd_ret_h0_rdv", h0_readdatavalid, !rd_host[i]);
            check("rd_ret_h1_rdv", h1_readdatavalid, rd_host[i]);
            check("rd_ret_data",   rd_host[i] ? h1_readdata : h0_readdata, rd_data[i]);
            cyc();
        end
        m_readdatavalid = 1'b0;
        check("rd_pending_zero", pending_count, 0);
        check("rd_no_err",       err_rdv,       0);

        // Pending limit: 8 outstanding h0 reads, a 9th must wait.
        for (int i = 0; i < 8; i++) begin
            h0_read    = 1'b1;
            h0_address = 20'(i);
            settle();
            check("lim_fill_h0_wait", h0_waitrequest, 0);
            cyc();
        end
        h0_address = 20'h00100;
        h1_write   = 1'b1;
        h1_address = 20'h00200;
        settle();
        check("lim_pending_full", pending_count,  8);
        check("lim_9th_h0_wait",  h0_waitrequest, 1);
        check("lim_h1_wr_grant",  h1_waitrequest, 0);
        cyc();
        h1_write        = 1'b0;
        m_readdatavalid = 1'b1;
        m_readdata      = 16'h0F00;
        settle();
        check("lim_ret_h0_rdv",   h0_readdatavalid, 1);
        check("lim_ret_still_wait", h0_waitrequest, 1);
        cyc();
        // 9th read granted while another return pops the FIFO.
        m_readdata = 16'h0F01;
        settle();
        check("lim_pending_7",    pending_count,    7);
        check("lim_9th_granted",  h0_waitrequest,   0);
        check("lim_pushpop_rdv",  h0_readdatavalid, 1);
        cyc();
        h0_read         = 1'b0;
        m_readdatavalid = 1'b0;
        settle();
        check("lim_pushpop_cnt",  pending_count, 7);
        check("lim_9th_m_addr",   m_address,     20'h00100);
        for (int i = 0; i < 7; i++) begin
            m_readdatavalid = 1'b1;
            settle();
            check("lim_drain_h0_rdv", h0_readdatavalid, 1);
            cyc();
        end
        m_readdatavalid = 1'b0;
        check("lim_drained", pending_count, 0);

        // Spurious return with nothing outstanding.
        m_readdatavalid = 1'b1;
        m_readdata      = 16'hDEAD;
        settle();
        check("spur_h0_rdv", h0_readdatavalid, 0);
        check("spur_h1_rdv", h1_readdatavalid, 0);
        cyc();
        m_readdatavalid = 1'b0;
        check("spur_err_set", err_rdv, 1);
        cyc();
        check("spur_err_sticky", err_rdv, 1);

        // Leave a read outstanding, then reset for one cycle.
        h0_read    = 1'b1;
        h0_address = 20'h00777;
        cyc();
        h0_read = 1'b0;
        settle();
        check("pre_rst_pending", pending_count, 1);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        check("post_rst_err",     err_rdv,       0);
        check("post_rst_pending", pending_count, 0);
        check("post_rst_m_read",  m_read,        0);

        // Stale return after reset is flagged and not routed.
        m_readdatavalid = 1'b1;
        settle();
        check("stale_h0_rdv", h0_readdatavalid, 0);
        cyc();
        m_readdatavalid = 1'b0;
        check("stale_err", err_rdv, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
